riscboy_ppu_sprite_fetch_agu: RTL and testbench
===============================================

Name: riscboy_ppu_sprite_fetch_agu

Overview:
- Scanline-scheduled address generator for the PPU sprite pipeline: the generalised successor to the per-sprite combinational coordinate/address unit.
- At each line start, a scan FSM walks all sprites, one per cycle, and latches each sprite's Y-intersection and texel row.
- It then arbitrates sprite fetch requests round-robin and issues aligned tile-memory reads. Outstanding reads are pipelined, and returned data is routed back to the requesting sprite.
- Adds 8/16/32 tile sizes, per-sprite X/Y flip, and multiple outstanding transactions.

Parameters:
W_DATA, 32, bus data width (power of 2, ≥8)
W_ADDR, 32, bus address width
W_COORD, 10, beam/sprite coordinate width
N_SPRITE, 16, sprite channel count (≥2)
MAX_OUTSTANDING, 2, max accepted-but-unreturned reads (≥1)
W_SPRITE_ID, $clog2(N_SPRITE), derived: sprite index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
line_start  in  1  pulse: start scan for beam_y
beam_y  in  W_COORD  current scanline, sampled on line_start
cfg_sprite_pos_x  in  N_SPRITE*W_COORD  per-sprite top-left X (unused here; carried for bus-width symmetry)
cfg_sprite_pos_y  in  N_SPRITE*W_COORD  per-sprite top-left Y
cfg_sprite_tile  in  N_SPRITE*8  per-sprite tile index
cfg_sprite_flip  in  N_SPRITE*2  per-sprite {flip_y, flip_x}
cfg_sprite_tmbase  in  24  tile memory base, byte address = tmbase<<8
cfg_sprite_tilesize  in  2  0: 8px, 1: 16px, 2/3: 32px
cfg_sprite_log_pixsize  in  3  log2 bits per pixel, 0..4
scan_busy  out  1  scan FSM in SCAN
scan_done  out  1  one-cycle pulse at end of scan
sprite_active  out  N_SPRITE  sprite intersects latched line
sprite_bus_vld  in  N_SPRITE  per-sprite fetch request
sprite_bus_u  in  N_SPRITE*5  requested pixel column (pre-flip)
sprite_bus_rdy  out  N_SPRITE  one-hot: request's address accepted
sprite_bus_dvld  out  N_SPRITE  one-hot: returned data for that sprite
sprite_bus_data  out  W_DATA  returned data, broadcast
bus_vld  out  1  address-phase request
bus_addr  out  W_ADDR  word-aligned byte address
bus_size  out  2  constant log2(W_DATA/8)
bus_rdy  in  1  address accepted this cycle
bus_dvld  in  1  read data returning (in order)
bus_data  in  W_DATA  read data

Behaviour:
- Reset:
  - FSM=IDLE; sprite_active=0; latched line=0; all per-sprite v regs=0.
  - RR pointer=0; grant lock clear; ID FIFO empty.
  - Outputs scan_busy, scan_done, bus_vld, sprite_bus_rdy, sprite_bus_dvld all 0.
- tsize = 8/16/32 per cfg_sprite_tilesize; the tsize field width is lt = 3/4/5 bits.
- Scan FSM, states IDLE, SCAN, DONE:
  - line_start in any state → SCAN, idx=0, latch beam_y, sprite_active cleared the same edge.
  - In SCAN, each cycle evaluates sprite idx:
    - dy = beam_y − pos_y, computed at W_COORD bits modulo.
    - active iff dy < tsize.
    - v = flip_y ? tsize−1−dy : dy, truncated to 5 bits; active bit and v are written at the edge.
  - idx = N_SPRITE−1 → DONE. DONE lasts one cycle with scan_done=1, then → IDLE.
  - A scan takes exactly N_SPRITE cycles. line_start during SCAN restarts from idx 0.
- Arbitration:
  - Eligible = sprite_bus_vld & sprite_active.
  - When unlocked, grant = first eligible at or after the RR pointer (wrapping).
  - bus_vld = (grant≠0) && ((count<MAX_OUTSTANDING) || bus_dvld).
  - Once bus_vld=1, grant and bus_addr are held stable until bus_rdy: the lock is held regardless of the requester's vld or a rescan.
  - On bus_vld&bus_rdy:
    - sprite_bus_rdy[grant]=1 (combinational).
    - The sprite ID is pushed to the FIFO.
    - RR pointer = granted idx+1 mod N_SPRITE.
    - Lock released; a new grant may issue the next cycle.
- Address:
  - u' = flip_x ? tsize−1−u : u, at lt bits.
  - idx = {tile, v[lt−1:0], u'[lt−1:0]}.
  - addr = ((tmbase<<8) + ((idx<<log_pixsize)>>3)) with the low log2(W_DATA/8) bits cleared.
  - The addition carry wraps at W_ADDR.
- Return:
  - On bus_dvld: pop the FIFO head; sprite_bus_dvld[head]=1; sprite_bus_data=bus_data, all in the same cycle.
  - bus_dvld with the FIFO empty is ignored (no dvld output).
  - Simultaneous push and pop keeps count unchanged.
  - Count never exceeds MAX_OUTSTANDING.

Test Plan:
- Scan active test:
  - Stimulus: tilesize=16, pos_y[3]=100, pos_y[5]=120, line_start with beam_y=110.
  - Required: scan_busy for exactly 16 cycles, then scan_done pulse; sprite_active=0x0008.
- Flip address test:
  - Stimulus: N=16, W_DATA=32, tmbase=0x000200, tile[3]=2, flip_x, tilesize=8, log_pixsize=3, v=5, u=1.
  - Required: u'=6; idx=0xAE; bus_addr=0x200AC.
- Round robin:
  - Stimulus: sprites 0, 1, 2 active and requesting continuously; bus_rdy=1; data returned each cycle.
  - Required: grant order 0, 1, 2, 0; no starvation.
- Outstanding limit and ordering:
  - Stimulus: MAX_OUTSTANDING=2, bus_dvld=0, three requests.
  - Required: two accepted, then bus_vld=0.
  - Then bus_dvld pulses: dvld routed to the first, then the second ID.
  - bus_vld=1 already in the cycle of the first return.
- Stall stability:
  - Stimulus: bus_rdy=0 for 5 cycles while the granted sprite drops vld and a higher-priority sprite requests.
  - Required: bus_addr and grant unchanged; accepted on bus_rdy.
- Mid-flight reset:
  - Stimulus: assert rst with 2 reads outstanding and SCAN at idx 7.
  - Required: all outputs 0 immediately (asynchronous); later bus_dvld produces no sprite_bus_dvld.

Source files
------------

// File: rtl/riscboy_ppu_sprite_fetch_agu.sv
// Sprite fetch address generator: per-line sprite scan, round-robin fetch arbitration,
// tile texel address generation and in-order routing of returned read data.
module riscboy_ppu_sprite_fetch_agu #(
  parameter int W_DATA          = 32,
  parameter int W_ADDR          = 32,
  parameter int W_COORD         = 10,
  parameter int N_SPRITE        = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int W_SPRITE_ID     = $clog2(N_SPRITE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          line_start,
  input  logic [W_COORD-1:0]            beam_y,
  input  logic [N_SPRITE*W_COORD-1:0]   cfg_sprite_pos_x,
  input  logic [N_SPRITE*W_COORD-1:0]   cfg_sprite_pos_y,
  input  logic [N_SPRITE*8-1:0]         cfg_sprite_tile,
  input  logic [N_SPRITE*2-1:0]         cfg_sprite_flip,
  input  logic [23:0]                   cfg_sprite_tmbase,
  input  logic [1:0]                    cfg_sprite_tilesize,
  input  logic [2:0]                    cfg_sprite_log_pixsize,
  output logic                          scan_busy,
  output logic                          scan_done,
  output logic [N_SPRITE-1:0]           sprite_active,
  input  logic [N_SPRITE-1:0]           sprite_bus_vld,
  input  logic [N_SPRITE*5-1:0]         sprite_bus_u,
  output logic [N_SPRITE-1:0]           sprite_bus_rdy,
  output logic [N_SPRITE-1:0]           sprite_bus_dvld,
  output logic [W_DATA-1:0]             sprite_bus_data,
  output logic                          bus_vld,
  output logic [W_ADDR-1:0]             bus_addr,
  output logic [1:0]                    bus_size,
  input  logic                          bus_rdy,
  input  logic                          bus_dvld,
  input  logic [W_DATA-1:0]             bus_data
);

  localparam int LOG_BYTES = $clog2(W_DATA / 8);
  localparam int W_CNT     = $clog2(MAX_OUTSTANDING + 1);
  localparam int W_PTR     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int W_IDX1    = W_SPRITE_ID + 1;
  localparam logic [W_ADDR-1:0] ALIGN_MASK = ~W_ADDR'((64'd1 << LOG_BYTES) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  scan_state_t state, state_next;

  logic [W_SPRITE_ID-1:0] scan_idx;
  logic [W_COORD-1:0]     line_y;
  logic [N_SPRITE-1:0]    active;
  logic [4:0]             v_row [N_SPRITE];

  logic [W_COORD-1:0] pos_y_arr [N_SPRITE];
  logic [7:0]         tile_arr  [N_SPRITE];
  logic [1:0]         flip_arr  [N_SPRITE];
  logic [4:0]         u_arr     [N_SPRITE];

  logic [5:0] tsize;

  logic [N_SPRITE-1:0]    eligible;
  logic                   pick_any;
  logic [W_SPRITE_ID-1:0] pick_id;
  logic [W_ADDR-1:0]      pick_addr;

  logic                   locked;
  logic [W_SPRITE_ID-1:0] lock_id;
  logic [W_ADDR-1:0]      lock_addr;
  logic [W_SPRITE_ID-1:0] rr_ptr;

  logic                   gnt_any;
  logic [W_SPRITE_ID-1:0] gnt_id;
  logic                   accept;

  logic [W_SPRITE_ID-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [W_PTR-1:0]       wr_ptr, rd_ptr;
  logic [W_CNT-1:0]       count;
  logic                   push, pop;
  logic [W_SPRITE_ID-1:0] head_id;

  // Position X is not needed for row/column addressing.
  logic unused_inputs;
  assign unused_inputs = ^cfg_sprite_pos_x;

  genvar gi;
  generate
    for (gi = 0; gi < N_SPRITE; gi++) begin : g_sprite
      assign pos_y_arr[gi]       = cfg_sprite_pos_y[gi*W_COORD +: W_COORD];
      assign tile_arr[gi]        = cfg_sprite_tile[gi*8 +: 8];
      assign flip_arr[gi]        = cfg_sprite_flip[gi*2 +: 2];
      assign u_arr[gi]           = sprite_bus_u[gi*5 +: 5];
      assign sprite_bus_rdy[gi]  = accept && (gnt_id == W_SPRITE_ID'(gi));
      assign sprite_bus_dvld[gi] = pop && (head_id == W_SPRITE_ID'(gi));
    end
  endgenerate

  always_comb begin
    case (cfg_sprite_tilesize)
      2'd0:    tsize = 6'd8;
      2'd1:    tsize = 6'd16;
      default: tsize = 6'd32;
    endcase
  end

  // ---------------- Scan FSM ----------------
  logic [W_COORD-1:0] scan_dy;
  logic               scan_hit;
  logic [4:0]         scan_v;

  always_comb begin
    scan_dy  = line_y - pos_y_arr[scan_idx];
    scan_hit = scan_dy < W_COORD'(tsize);
    // tsize[4:0] is 0 for 32px tiles, so the 5-bit subtraction still yields 31-dy.
    scan_v   = flip_arr[scan_idx][1] ? (tsize[4:0] - 5'd1 - scan_dy[4:0]) : scan_dy[4:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = IDLE;
      SCAN: if (scan_idx == W_SPRITE_ID'(N_SPRITE - 1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (line_start) state_next = SCAN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx <= '0;
      line_y   <= '0;
      active   <= '0;
      for (int i = 0; i < N_SPRITE; i++) v_row[i] <= '0;
    end else if (line_start) begin
      scan_idx <= '0;
      line_y   <= beam_y;
      active   <= '0;
    end else if (state == SCAN) begin
      active[scan_idx] <= scan_hit;
      v_row[scan_idx]  <= scan_v;
      scan_idx         <= scan_idx + 1'b1;
    end
  end

  assign scan_busy     = (state == SCAN);
  assign scan_done     = (state == DONE);
  assign sprite_active = active;

  // ---------------- Round-robin arbitration ----------------
  assign eligible = sprite_bus_vld & active;

  always_comb begin
    logic [W_IDX1-1:0]      j_ext;
    logic [W_SPRITE_ID-1:0] j;
    pick_any = 1'b0;
    pick_id  = '0;
    j_ext    = '0;
    j        = '0;
    for (int i = 0; i < N_SPRITE; i++) begin
      j_ext = {1'b0, rr_ptr} + W_IDX1'(i);
      if (j_ext >= W_IDX1'(N_SPRITE)) j_ext = j_ext - W_IDX1'(N_SPRITE);
      j = j_ext[W_SPRITE_ID-1:0];
      if (!pick_any && eligible[j]) begin
        pick_any = 1'b1;
        pick_id  = j;
      end
    end
  end

  // ---------------- Texel address for the candidate grant ----------------
  logic [4:0]  addr_u;
  logic [17:0] tex_idx;
  logic [25:0] byte_off;

  always_comb begin
    addr_u = flip_arr[pick_id][0] ? (tsize[4:0] - 5'd1 - u_arr[pick_id]) : u_arr[pick_id];
    case (cfg_sprite_tilesize)
      2'd0:    tex_idx = 18'({tile_arr[pick_id], v_row[pick_id][2:0], addr_u[2:0]});
      2'd1:    tex_idx = 18'({tile_arr[pick_id], v_row[pick_id][3:0], addr_u[3:0]});
      default: tex_idx = {tile_arr[pick_id], v_row[pick_id], addr_u};
    endcase
    byte_off  = ({8'd0, tex_idx} << cfg_sprite_log_pixsize) >> 3;
    pick_addr = (W_ADDR'({cfg_sprite_tmbase, 8'h00}) + W_ADDR'(byte_off)) & ALIGN_MASK;
  end

  // A locked grant keeps sprite and address frozen until the bus accepts.
  always_comb begin
    if (locked) begin
      gnt_any  = 1'b1;
      gnt_id   = lock_id;
      bus_addr = lock_addr;
    end else begin
      gnt_any  = pick_any;
      gnt_id   = pick_id;
      bus_addr = pick_addr;
    end
  end

  assign bus_vld  = gnt_any && ((count < W_CNT'(MAX_OUTSTANDING)) || bus_dvld);
  assign accept   = bus_vld && bus_rdy;
  assign bus_size = 2'(LOG_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked    <= 1'b0;
      lock_id   <= '0;
      lock_addr <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      locked <= 1'b0;
      rr_ptr <= (gnt_id == W_SPRITE_ID'(N_SPRITE - 1)) ? '0 : gnt_id + 1'b1;
    end else if (bus_vld) begin
      locked    <= 1'b1;
      lock_id   <= gnt_id;
      lock_addr <= bus_addr;
    end
  end

  // ---------------- Outstanding-read ID FIFO ----------------
  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push    = accept;
  assign pop     = bus_dvld && (count != '0);
  assign head_id = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= gnt_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign sprite_bus_data = bus_data;

endmodule

// File: tb/tb_riscboy_ppu_sprite_fetch_agu.sv
// Directed bench for the sprite fetch AGU: scan, address/flip, round robin,
// outstanding limit, stall stability and asynchronous reset.
module tb_riscboy_ppu_sprite_fetch_agu;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_start;
  logic [9:0]   beam_y;
  logic [159:0] pos_x, pos_y;
  logic [127:0] tile;
  logic [31:0]  flip;
  logic [23:0]  tmbase;
  logic [1:0]   tilesize;
  logic [2:0]   log_pixsize;
  logic         scan_busy, scan_done;
  logic [15:0]  sprite_active, sb_vld, sb_rdy, sb_dvld;
  logic [79:0]  sb_u;
  logic [31:0]  sb_data;
  logic         bus_vld;
  logic [31:0]  bus_addr;
  logic [1:0]   bus_size;
  logic         bus_rdy, bus_dvld;
  logic [31:0]  bus_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscboy_ppu_sprite_fetch_agu dut (
    .clk                    (clk),
    .rst                    (rst),
    .line_start             (line_start),
    .beam_y                 (beam_y),
    .cfg_sprite_pos_x       (pos_x),
    .cfg_sprite_pos_y       (pos_y),
    .cfg_sprite_tile        (tile),
    .cfg_sprite_flip        (flip),
    .cfg_sprite_tmbase      (tmbase),
    .cfg_sprite_tilesize    (tilesize),
    .cfg_sprite_log_pixsize (log_pixsize),
    .scan_busy              (scan_busy),
    .scan_done              (scan_done),
    .sprite_active          (sprite_active),
    .sprite_bus_vld         (sb_vld),
    .sprite_bus_u           (sb_u),
    .sprite_bus_rdy         (sb_rdy),
    .sprite_bus_dvld        (sb_dvld),
    .sprite_bus_data        (sb_data),
    .bus_vld                (bus_vld),
    .bus_addr               (bus_addr),
    .bus_size               (bus_size),
    .bus_rdy                (bus_rdy),
    .bus_dvld               (bus_dvld),
    .bus_data               (bus_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the FSM back in IDLE.
  task automatic do_scan(input logic [9:0] y);
    int n;
    line_start = 1'b1;
    beam_y     = y;
    cyc();
    line_start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!scan_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (scan_done !== 1'b1) begin
      errors++;
      $display("FAIL scan_timeout got scan_done=%0b exp=1", scan_done);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL rst_scan_busy got=%0b exp=0", scan_busy); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL rst_scan_done got=%0b exp=0", scan_done); end
    checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL rst_bus_vld got=%0b exp=0", bus_vld); end
    checks++; if (sb_rdy !== 16'h0) begin errors++; $display("FAIL rst_sb_rdy got=%h exp=0000", sb_rdy); end
    checks++; if (sb_dvld !== 16'h0) begin errors++; $display("FAIL rst_sb_dvld got=%h exp=0000", sb_dvld); end
    checks++; if (sprite_active !== 16'h0) begin errors++; $display("FAIL rst_active got=%h exp=0000", sprite_active); end
    checks++; if (bus_size !== 2'd2) begin errors++; $display("FAIL rst_bus_size got=%0d exp=2", bus_size); end
    cyc();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_scan_active();
    int busy_n;
    pos_y = '0;
    pos_y[3*10 +: 10] = 10'd100;
    pos_y[5*10 +: 10] = 10'd120;
    tilesize   = 2'd1;
    flip       = '0;
    line_start = 1'b1;
    beam_y     = 10'd110;
    cyc();
    line_start = 1'b0;
    busy_n = 0;
    @(negedge clk);
    while (scan_busy && busy_n < 40) begin
      busy_n++;
      @(negedge clk);
    end
    checks++; if (busy_n !== 16) begin errors++; $display("FAIL scan_busy_cycles got=%0d exp=16", busy_n); end
    checks++; if (scan_done !== 1'b1) begin errors++; $display("FAIL scan_done_pulse got=%0b exp=1", scan_done); end
    checks++; if (sprite_active !== 16'h0008) begin errors++; $display("FAIL scan_active got=%h exp=0008", sprite_active); end
    @(negedge clk);
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL scan_done_single got=%0b exp=0", scan_done); end
    cyc();
    $display("test_scan_active busy=%0d active=%h", busy_n, sprite_active);
  endtask

  logic [1:0]  ts_tab  [3] = '{2'd0, 2'd1, 2'd2};
  logic [1:0]  fl_tab  [3] = '{2'b01, 2'b10, 2'b11};
  logic [4:0]  u_tab   [3] = '{5'd1, 5'd3, 5'd7};
  logic [2:0]  lp_tab  [3] = '{3'd3, 3'd2, 3'd4};
  logic [31:0] adr_tab [3] = '{32'h0002_00AC, 32'h0002_0150, 32'h0002_16B0};

  task automatic test_flip_addr();
    tmbase = 24'h000200;
    tile[3*8 +: 8] = 8'd2;
    for (int i = 0; i < 3; i++) begin
      tilesize        = ts_tab[i];
      flip[3*2 +: 2]  = fl_tab[i];
      log_pixsize     = lp_tab[i];
      sb_u[3*5 +: 5]  = u_tab[i];
      do_scan(10'd105);
      sb_vld  = 16'h0008;
      bus_rdy = 1'b0;
      @(negedge clk);
      checks++; if (sprite_active !== 16'h0008) begin errors++; $display("FAIL fa_active[%0d] got=%h exp=0008", i, sprite_active); end
      checks++; if (bus_vld !== 1'b1) begin errors++; $display("FAIL fa_bus_vld[%0d] got=%0b exp=1", i, bus_vld); end
      checks++; if (bus_addr !== adr_tab[i]) begin errors++; $display("FAIL fa_addr[%0d] got=%h exp=%h", i, bus_addr, adr_tab[i]); end
      checks++; if (sb_rdy !== 16'h0) begin errors++; $display("FAIL fa_rdy_low[%0d] got=%h exp=0000", i, sb_rdy); end
      cyc();
      bus_rdy = 1'b1;
      @(negedge clk);
      checks++; if (sb_rdy !== 16'h0008) begin errors++; $display("FAIL fa_rdy[%0d] got=%h exp=0008", i, sb_rdy); end
      cyc();
      sb_vld   = '0;
      bus_rdy  = 1'b0;
      bus_dvld = 1'b1;
      bus_data = 32'hA500_0000 + i;
      @(negedge clk);
      checks++; if (sb_dvld !== 16'h0008) begin errors++; $display("FAIL fa_dvld[%0d] got=%h exp=0008", i, sb_dvld); end
      checks++; if (sb_data !== 32'hA500_0000 + i) begin errors++; $display("FAIL fa_data[%0d] got=%h exp=%h", i, sb_data, 32'hA500_0000 + i); end
      cyc();
      bus_dvld = 1'b0;
      $display("test_flip_addr vec=%0d addr=%h", i, adr_tab[i]);
    end
  endtask

  logic [15:0] rr_rdy_tab  [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0001};
  logic [15:0] rr_dvld_tab [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0004};

  task automatic test_round_robin();
    tilesize    = 2'd0;
    log_pixsize = 3'd3;
    flip        = '0;
    for (int s = 0; s < 3; s++) pos_y[s*10 +: 10] = 10'd200;
    tile[0*8 +: 8] = 8'h10;
    tile[1*8 +: 8] = 8'h18;
    tile[2*8 +: 8] = 8'h20;
    sb_u[0*5 +: 5] = 5'd2;
    sb_u[1*5 +: 5] = 5'd0;
    sb_u[2*5 +: 5] = 5'd5;
    do_scan(10'd200);
    sb_vld   = 16'h0007;
    bus_rdy  = 1'b1;
    bus_dvld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus_data = 32'h1000_0000 + k;
      @(negedge clk);
      if (k == 0) begin
        checks++; if (sprite_active !== 16'h0007) begin errors++; $display("FAIL rr_active got=%h exp=0007", sprite_active); end
        checks++; if (bus_addr !== 32'h0002_0400) begin errors++; $display("FAIL rr_addr0 got=%h exp=00020400", bus_addr); end
      end
      checks++; if (sb_rdy !== rr_rdy_tab[k]) begin errors++; $display("FAIL rr_grant[%0d] got=%h exp=%h", k, sb_rdy, rr_rdy_tab[k]); end
      checks++; if (sb_dvld !== rr_dvld_tab[k]) begin errors++; $display("FAIL rr_dvld[%0d] got=%h exp=%h", k, sb_dvld, rr_dvld_tab[k]); end
      $display("test_round_robin cycle=%0d rdy=%h dvld=%h", k, sb_rdy, sb_dvld);
      cyc();
    end
    sb_vld  = '0;
    bus_rdy = 1'b0;
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0001) begin errors++; $display("FAIL rr_drain got=%h exp=0001", sb_dvld); end
    cyc();
    bus_dvld = 1'b0;
  endtask

  task automatic test_outstanding();
    sb_vld   = 16'h0007;
    bus_rdy  = 1'b1;
    bus_dvld = 1'b0;
    @(negedge clk);
    checks++; if (sb_rdy !== 16'h0002) begin errors++; $display("FAIL os_acc1 got=%h exp=0002", sb_rdy); end
    cyc();
    @(negedge clk);
    checks++; if (sb_rdy !== 16'h0004) begin errors++; $display("FAIL os_acc2 got=%h exp=0004", sb_rdy); end
    cyc();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL os_full_vld[%0d] got=%0b exp=0", k, bus_vld); end
      checks++; if (sb_rdy !== 16'h0) begin errors++; $display("FAIL os_full_rdy[%0d] got=%h exp=0000", k, sb_rdy); end
      cyc();
    end
    bus_dvld = 1'b1;
    bus_data = 32'h0000_BEEF;
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0002) begin errors++; $display("FAIL os_ret1 got=%h exp=0002", sb_dvld); end
    checks++; if (bus_vld !== 1'b1) begin errors++; $display("FAIL os_vld_on_ret got=%0b exp=1", bus_vld); end
    checks++; if (sb_rdy !== 16'h0001) begin errors++; $display("FAIL os_acc3 got=%h exp=0001", sb_rdy); end
    cyc();
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0004) begin errors++; $display("FAIL os_ret2 got=%h exp=0004", sb_dvld); end
    checks++; if (sb_rdy !== 16'h0002) begin errors++; $display("FAIL os_acc4 got=%h exp=0002", sb_rdy); end
    cyc();
    sb_vld  = '0;
    bus_rdy = 1'b0;
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0001) begin errors++; $display("FAIL os_ret3 got=%h exp=0001", sb_dvld); end
    cyc();
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0002) begin errors++; $display("FAIL os_ret4 got=%h exp=0002", sb_dvld); end
    cyc();
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0000) begin errors++; $display("FAIL os_ret_empty got=%h exp=0000", sb_dvld); end
    cyc();
    bus_dvld = 1'b0;
    $display("test_outstanding done");
  endtask

  task automatic test_stall();
    int n;
    sb_vld  = 16'h0004;
    bus_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        sb_vld     = 16'h0001;
        line_start = 1'b1;
        beam_y     = 10'd200;
      end
      @(negedge clk);
      checks++; if (bus_vld !== 1'b1) begin errors++; $display("FAIL st_vld[%0d] got=%0b exp=1", k, bus_vld); end
      checks++; if (bus_addr !== 32'h0002_0804) begin errors++; $display("FAIL st_addr[%0d] got=%h exp=00020804", k, bus_addr); end
      checks++; if (sb_rdy !== 16'h0) begin errors++; $display("FAIL st_rdy[%0d] got=%h exp=0000", k, sb_rdy); end
      $display("test_stall cycle=%0d addr=%h", k, bus_addr);
      cyc();
      line_start = 1'b0;
    end
    bus_rdy = 1'b1;
    @(negedge clk);
    checks++; if (sb_rdy !== 16'h0004) begin errors++; $display("FAIL st_accept got=%h exp=0004", sb_rdy); end
    checks++; if (bus_addr !== 32'h0002_0804) begin errors++; $display("FAIL st_accept_addr got=%h exp=00020804", bus_addr); end
    cyc();
    @(negedge clk);
    checks++; if (sb_rdy !== 16'h0001) begin errors++; $display("FAIL st_next_grant got=%h exp=0001", sb_rdy); end
    checks++; if (bus_addr !== 32'h0002_0400) begin errors++; $display("FAIL st_next_addr got=%h exp=00020400", bus_addr); end
    cyc();
    sb_vld   = '0;
    bus_rdy  = 1'b0;
    bus_dvld = 1'b1;
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0004) begin errors++; $display("FAIL st_ret1 got=%h exp=0004", sb_dvld); end
    cyc();
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0001) begin errors++; $display("FAIL st_ret2 got=%h exp=0001", sb_dvld); end
    cyc();
    bus_dvld = 1'b0;
    n = 0;
    @(negedge clk);
    while (!scan_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (scan_done !== 1'b1) begin errors++; $display("FAIL st_rescan_timeout got=%0b exp=1", scan_done); end
    cyc();
  endtask

  task automatic test_midflight_reset();
    sb_vld   = 16'h0003;
    bus_rdy  = 1'b1;
    bus_dvld = 1'b0;
    @(negedge clk);
    checks++; if (sb_rdy !== 16'h0002) begin errors++; $display("FAIL mr_acc1 got=%h exp=0002", sb_rdy); end
    cyc();
    @(negedge clk);
    checks++; if (sb_rdy !== 16'h0001) begin errors++; $display("FAIL mr_acc2 got=%h exp=0001", sb_rdy); end
    cyc();
    line_start = 1'b1;
    beam_y     = 10'd200;
    @(negedge clk);
    checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL mr_full got=%0b exp=0", bus_vld); end
    cyc();
    line_start = 1'b0;
    repeat (7) cyc();
    bus_dvld = 1'b1;
    #1;
    checks++; if (scan_busy !== 1'b1) begin errors++; $display("FAIL mr_pre_busy got=%0b exp=1", scan_busy); end
    checks++; if (sb_dvld !== 16'h0002) begin errors++; $display("FAIL mr_pre_dvld got=%h exp=0002", sb_dvld); end
    checks++; if (bus_vld !== 1'b1) begin errors++; $display("FAIL mr_pre_vld got=%0b exp=1", bus_vld); end
    rst = 1'b1;
    #1;
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL mr_busy got=%0b exp=0", scan_busy); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL mr_done got=%0b exp=0", scan_done); end
    checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL mr_vld got=%0b exp=0", bus_vld); end
    checks++; if (sb_rdy !== 16'h0) begin errors++; $display("FAIL mr_rdy got=%h exp=0000", sb_rdy); end
    checks++; if (sb_dvld !== 16'h0) begin errors++; $display("FAIL mr_dvld got=%h exp=0000", sb_dvld); end
    checks++; if (sprite_active !== 16'h0) begin errors++; $display("FAIL mr_active got=%h exp=0000", sprite_active); end
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (sb_dvld !== 16'h0) begin errors++; $display("FAIL mr_late_dvld got=%h exp=0000", sb_dvld); end
    checks++; if (bus_vld !== 1'b0) begin errors++; $display("FAIL mr_late_vld got=%0b exp=0", bus_vld); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL mr_late_busy got=%0b exp=0", scan_busy); end
    cyc();
    bus_dvld = 1'b0;
    sb_vld   = '0;
    bus_rdy  = 1'b0;
    $display("test_midflight_reset done");
  endtask

  initial begin
    rst         = 1'b1;
    line_start  = 1'b0;
    beam_y      = '0;
    pos_x       = '0;
    pos_y       = '0;
    tile        = '0;
    flip        = '0;
    tmbase      = '0;
    tilesize    = '0;
    log_pixsize = '0;
    sb_vld      = '0;
    sb_u        = '0;
    bus_rdy     = 1'b0;
    bus_dvld    = 1'b0;
    bus_data    = '0;
    test_reset();
    test_scan_active();
    test_flip_addr();
    test_round_robin();
    test_outstanding();
    test_stall();
    test_midflight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
